uart_rx: RTL and testbench

Serial receiver for the UART path, pairing with the existing transmitter on the same 8N1 link. Oversamples the asynchronous `rx_in` line using a shared 16x baud tick. Validates the start bit at mid-bit, shifts in 8 data bits LSB-first, and checks the stop bit. Presents each received byte with a one-cycle `rx_valid` strobe to the downstream consumer (FIFO or MIC-1 I/O register).

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry,
// common to the receiver and the transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input.
// RESET_VAL should match the input's idle level so reset causes no false edge.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start validation at mid-bit, LSB-first data
// shift, stop-bit check, and single-cycle rx_valid / frame_err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_T   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic rx_s;

    uart_state_t          state_reg,  state_next;
    logic [TW-1:0]        tick_reg,   tick_next;
    logic [BW-1:0]        bit_reg,    bit_next;
    logic [DATA_BITS-1:0] shift_reg,  shift_next;
    logic [DATA_BITS-1:0] data_reg,   data_next;
    logic                 valid_reg,  valid_next;
    logic                 err_reg,    err_next;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            tick_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        err_next   = 1'b0;

        if (baud_tick) begin
            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_next = START;
                        tick_next  = '0;
                    end
                end
                START: begin
                    // Half a bit into the start bit: a high line means the edge was a glitch.
                    if (tick_reg == HALF_M1) begin
                        tick_next = '0;
                        if (!rx_s) begin
                            state_next = DATA;
                            bit_next   = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_reg == LAST_T) begin
                        tick_next  = '0;
                        shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_reg == LAST_BIT) begin
                            state_next = STOP;
                        end else begin
                            bit_next = bit_reg + 1'b1;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_reg == LAST_T) begin
                        tick_next  = '0;
                        state_next = IDLE;
                        if (rx_s) begin
                            data_next  = shift_reg;
                            valid_next = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else begin
                        tick_next = tick_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    tick_next  = '0;
                end
            endcase
        end
    end

    assign data_out  = data_reg;
    assign rx_valid  = valid_reg;
    assign frame_err = err_reg;
    assign rx_busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, hand-written glitch and reset-abort
// sequences, and random frames scored against a frame-level model.
module tb_uart_rx;

    localparam int NOM = 64;   // clk per bit: baud_tick every 4 clk, 16 ticks per bit

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick;
    logic       rx_in = 1'b1;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int tick_div = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] model_data = 8'h00;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         bit_clks;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
    assign baud_tick = (tick_div == 3);

    always @(negedge clk) begin
        if (rx_valid) valid_cnt++;
        if (frame_err) err_cnt++;
        if (rx_valid && frame_err) both_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int clks);
        rx_in = v;
        repeat (clks) @(negedge clk);
    endtask

    // Start bit, LSB-first data, stop bit, then one idle bit.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int bc);
        hold(1'b0, bc);
        for (int i = 0; i < 8; i++) begin
            hold(d[i], bc);
            if (i == 1) check("busy_mid_frame", int'(rx_busy), 1);
        end
        hold(stop_ok ? 1'b1 : 1'b0, bc);
        hold(1'b1, bc);
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input bit stop_ok,
                             input int bc, input int exp_valid, input int exp_err,
                             input logic [7:0] exp_data);
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(d, stop_ok, bc);
        check({name, "_valid"}, valid_cnt - v0, exp_valid);
        check({name, "_ferr"}, err_cnt - e0, exp_err);
        check({name, "_data"}, int'(data_out), int'(exp_data));
        check({name, "_busy_after"}, int'(rx_busy), 0);
        $display("frame %s d=0x%02h stop=%0d bclk=%0d -> data_out=0x%02h valid+%0d err+%0d",
                 name, d, stop_ok, bc, data_out, valid_cnt - v0, err_cnt - e0);
    endtask

    initial begin
        int v0, e0;
        logic [7:0] rd;
        bit rs;

        vecs[0] = '{8'hA5, 1'b1, NOM,      1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, NOM,      0, 1, 8'hA5};
        vecs[2] = '{8'h00, 1'b1, NOM,      1, 0, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, NOM,      1, 0, 8'hFF};
        vecs[4] = '{8'h96, 1'b1, 66,       1, 0, 8'h96};
        vecs[5] = '{8'h96, 1'b1, 62,       1, 0, 8'h96};

        repeat (3) @(negedge clk);
        check("rst_data", int'(data_out), 0);
        check("rst_valid", int'(rx_valid), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_busy", int'(rx_busy), 0);
        rst = 1'b0;
        repeat (2 * NOM) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stop_ok, vecs[i].bit_clks,
                      vecs[i].exp_valid, vecs[i].exp_err, vecs[i].exp_data);
            model_data = vecs[i].exp_data;
        end

        // Short low glitch on an idle line must be rejected at the mid-start check.
        repeat (NOM) @(negedge clk);
        v0 = valid_cnt;
        e0 = err_cnt;
        hold(1'b0, 12);
        hold(1'b1, 3 * NOM);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_ferr", err_cnt - e0, 0);
        check("glitch_data", int'(data_out), int'(model_data));
        check("glitch_busy", int'(rx_busy), 0);
        $display("glitch 12clk -> valid+%0d err+%0d data_out=0x%02h", valid_cnt - v0, err_cnt - e0, data_out);

        // Reset in the middle of bit 4 of 0x81 aborts the frame silently.
        v0 = valid_cnt;
        e0 = err_cnt;
        rd = 8'h81;
        hold(1'b0, NOM);
        for (int i = 0; i < 4; i++) hold(rd[i], NOM);
        hold(rd[4], NOM / 2);
        rst = 1'b1;
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_busy", int'(rx_busy), 0);
        check("midrst_data", int'(data_out), 0);
        rst = 1'b0;
        model_data = 8'h00;
        hold(1'b1, 2 * NOM);
        check("midrst_valid", valid_cnt - v0, 0);
        check("midrst_ferr", err_cnt - e0, 0);
        $display("reset mid-frame 0x81 -> valid+%0d err+%0d data_out=0x%02h", valid_cnt - v0, err_cnt - e0, data_out);
        run_frame("after_rst", 8'h55, 1'b1, NOM, 1, 0, 8'h55);
        model_data = 8'h55;

        // Random frames against the frame-level model.
        for (int i = 0; i < 16; i++) begin
            rd = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            run_frame($sformatf("rnd%0d", i), rd, rs, NOM, rs ? 1 : 0, rs ? 0 : 1,
                      rs ? rd : model_data);
            if (rs) model_data = rd;
        end

        check("no_overlap", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
